// File: rtl/qsfp_tx_arbiter_pkg.sv
// Shared encodings for the QSFP transmit arbiter and the status blocks that read its counters.
package qsfp_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

    // Source indices as they appear on OUT_AXIS_TUSER and in the status registers.
    localparam logic SRC_GEN = 1'b0;
    localparam logic SRC_AUX = 1'b1;

endpackage

// File: rtl/qsfp_tx_arbiter_axis_out_reg.sv
// One-deep registered AXI-Stream output stage with a ready-through path toward the arbiter.
module axis_out_reg #(
    parameter int DATA_W = 512
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_user,
    output logic              load_ready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tuser,
    input  logic              m_tready
);

    // Handshake: a beat moves when valid && ready on the same edge; once valid is high the
    // register holds data/last/user unchanged until ready is seen. A new beat may be loaded
    // in the same cycle the current one leaves, so the stage sustains one beat per clock.
    assign load_ready = !m_tvalid || m_tready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (load) begin
            m_tdata  <= load_data;
            m_tvalid <= 1'b1;
            m_tlast  <= load_last;
            m_tuser  <= load_user;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/qsfp_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging two AXI-Stream sources onto the QSFP TX stream.
module qsfp_tx_arbiter
    import qsfp_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic              S0_AXIS_TVALID,
    input  logic              S0_AXIS_TLAST,
    output logic              S0_AXIS_TREADY,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic              S1_AXIS_TVALID,
    input  logic              S1_AXIS_TLAST,
    output logic              S1_AXIS_TREADY,
    output logic [DATA_W-1:0] OUT_AXIS_TDATA,
    output logic              OUT_AXIS_TVALID,
    output logic              OUT_AXIS_TLAST,
    output logic              OUT_AXIS_TUSER,
    input  logic              OUT_AXIS_TREADY,
    output logic [CNT_W-1:0]  pkt_count0,
    output logic [CNT_W-1:0]  pkt_count1,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e state, state_next;
    logic       last_grant;
    logic       slot_ready;
    logic       accept0, accept1;
    logic       load;

    // TREADY depends only on state and the output slot, never on the source TVALIDs.
    assign S0_AXIS_TREADY = (state == ARB_GRANT0) && slot_ready;
    assign S1_AXIS_TREADY = (state == ARB_GRANT1) && slot_ready;

    assign accept0 = S0_AXIS_TVALID && S0_AXIS_TREADY;
    assign accept1 = S1_AXIS_TVALID && S1_AXIS_TREADY;
    assign load    = accept0 || accept1;

    assign busy      = (state != ARB_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    state_next = (last_grant == SRC_GEN) ? ARB_GRANT1 : ARB_GRANT0;
                end else if (S0_AXIS_TVALID) begin
                    state_next = ARB_GRANT0;
                end else if (S1_AXIS_TVALID) begin
                    state_next = ARB_GRANT1;
                end
            end
            ARB_GRANT0: begin
                if (accept0 && S0_AXIS_TLAST) begin
                    if (S1_AXIS_TVALID)      state_next = ARB_GRANT1;
                    else if (S0_AXIS_TVALID) state_next = ARB_GRANT0;
                    else                     state_next = ARB_IDLE;
                end
            end
            ARB_GRANT1: begin
                if (accept1 && S1_AXIS_TLAST) begin
                    if (S0_AXIS_TVALID)      state_next = ARB_GRANT0;
                    else if (S1_AXIS_TVALID) state_next = ARB_GRANT1;
                    else                     state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            last_grant <= SRC_AUX;
        end else begin
            state <= state_next;
            if (state_next == ARB_GRANT0)      last_grant <= SRC_GEN;
            else if (state_next == ARB_GRANT1) last_grant <= SRC_AUX;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            if (accept0 && S0_AXIS_TLAST) pkt_count0 <= pkt_count0 + CNT_ONE;
            if (accept1 && S1_AXIS_TLAST) pkt_count1 <= pkt_count1 + CNT_ONE;
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .load_data  (accept1 ? S1_AXIS_TDATA : S0_AXIS_TDATA),
        .load_last  (accept1 ? S1_AXIS_TLAST : S0_AXIS_TLAST),
        .load_user  (accept1 ? SRC_AUX : SRC_GEN),
        .load_ready (slot_ready),
        .m_tdata    (OUT_AXIS_TDATA),
        .m_tvalid   (OUT_AXIS_TVALID),
        .m_tlast    (OUT_AXIS_TLAST),
        .m_tuser    (OUT_AXIS_TUSER),
        .m_tready   (OUT_AXIS_TREADY)
    );

endmodule

// File: tb/tb_qsfp_tx_arbiter.sv
// Directed bench for qsfp_tx_arbiter: a vector table for the first packet, then hand-written sequences.
module tb_qsfp_tx_arbiter;

    localparam int DATA_W = 512;
    localparam int CNT_W  = 32;
    localparam int EXP_W  = DATA_W + 2;
    localparam int CW     = EXP_W + 1;

    logic              clock = 1'b0;
    logic              resetn;
    logic [DATA_W-1:0] S0_AXIS_TDATA, S1_AXIS_TDATA, OUT_AXIS_TDATA;
    logic              S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
    logic              S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
    logic              OUT_AXIS_TVALID, OUT_AXIS_TLAST, OUT_AXIS_TUSER, OUT_AXIS_TREADY;
    logic [CNT_W-1:0]  pkt_count0, pkt_count1;
    logic              busy;
    logic [1:0]        state_dbg;

    always #5 clock = ~clock;

    qsfp_tx_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TVALID(S0_AXIS_TVALID),
        .S0_AXIS_TLAST(S0_AXIS_TLAST), .S0_AXIS_TREADY(S0_AXIS_TREADY),
        .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TVALID(S1_AXIS_TVALID),
        .S1_AXIS_TLAST(S1_AXIS_TLAST), .S1_AXIS_TREADY(S1_AXIS_TREADY),
        .OUT_AXIS_TDATA(OUT_AXIS_TDATA), .OUT_AXIS_TVALID(OUT_AXIS_TVALID),
        .OUT_AXIS_TLAST(OUT_AXIS_TLAST), .OUT_AXIS_TUSER(OUT_AXIS_TUSER),
        .OUT_AXIS_TREADY(OUT_AXIS_TREADY),
        .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
        .busy(busy), .state_dbg(state_dbg)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] wide(input logic [15:0] d);
        return {32{d}};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        s0v;
        logic [15:0] s0d;
        logic        s0l;
        logic        ordy;
        logic        e_s0r;
        logic        e_s1r;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_ol;
        logic        e_ou;
        int          e_c0;
        logic        e_busy;
    } vec_t;

    vec_t vecs[8];

    // ---------------- sequence engine ----------------
    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t            q0[$], q1[$];
    logic [EXP_W-1:0] exp_q[$];
    bit               en0, en1, ordy;
    int               cyc, out_cnt, first_out, last_out, s0_last_cyc, s1_first_cyc;
    bit               prev_stall;
    logic [CW-1:0]    prev_out;
    bit               st_s1r, st_last0;

    task automatic push_pkt(input int src, input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = base + 16'(i);
            b.l = (i == len - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            exp_q.push_back({src[0], b.l, wide(b.d)});
        end
    endtask

    task automatic clear_tracking();
        q0.delete();
        q1.delete();
        exp_q.delete();
        en0 = 0; en1 = 0; ordy = 1;
        out_cnt = 0; first_out = -1; last_out = -1;
        s0_last_cyc = -1; s1_first_cyc = -1;
        prev_stall = 0; cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        S0_AXIS_TVALID = 0; S0_AXIS_TLAST = 0; S0_AXIS_TDATA = '0;
        S1_AXIS_TVALID = 0; S1_AXIS_TLAST = 0; S1_AXIS_TDATA = '0;
        OUT_AXIS_TREADY = 1;
        clear_tracking();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic step();
        logic acc0, acc1;
        logic [EXP_W-1:0] e;
        @(negedge clock);
        S0_AXIS_TVALID  = en0 && (q0.size() > 0);
        S0_AXIS_TDATA   = (q0.size() > 0) ? wide(q0[0].d) : '0;
        S0_AXIS_TLAST   = (q0.size() > 0) ? q0[0].l : 1'b0;
        S1_AXIS_TVALID  = en1 && (q1.size() > 0);
        S1_AXIS_TDATA   = (q1.size() > 0) ? wide(q1[0].d) : '0;
        S1_AXIS_TLAST   = (q1.size() > 0) ? q1[0].l : 1'b0;
        OUT_AXIS_TREADY = ordy;
        #1;
        acc0     = S0_AXIS_TVALID && S0_AXIS_TREADY;
        acc1     = S1_AXIS_TVALID && S1_AXIS_TREADY;
        st_s1r   = S1_AXIS_TREADY;
        st_last0 = acc0 && S0_AXIS_TLAST;
        chk("ready_exclusive", CW'(S0_AXIS_TREADY && S1_AXIS_TREADY), '0);
        if (prev_stall)
            chk("stall_hold", {OUT_AXIS_TVALID, OUT_AXIS_TUSER, OUT_AXIS_TLAST, OUT_AXIS_TDATA}, prev_out);
        if (OUT_AXIS_TVALID && !ordy) begin
            chk("stall_s0_ready", CW'(S0_AXIS_TREADY), '0);
            chk("stall_s1_ready", CW'(S1_AXIS_TREADY), '0);
        end
        if (OUT_AXIS_TVALID && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", CW'(OUT_AXIS_TDATA[15:0]), CW'(16'hdead));
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", CW'({OUT_AXIS_TUSER, OUT_AXIS_TLAST, OUT_AXIS_TDATA}), CW'(e));
            end
            if (out_cnt == 0) first_out = cyc;
            last_out = cyc;
            out_cnt++;
            if (!OUT_AXIS_TUSER && OUT_AXIS_TLAST) s0_last_cyc = cyc;
            if (OUT_AXIS_TUSER && s1_first_cyc < 0) s1_first_cyc = cyc;
        end
        prev_stall = OUT_AXIS_TVALID && !ordy;
        prev_out   = {OUT_AXIS_TVALID, OUT_AXIS_TUSER, OUT_AXIS_TLAST, OUT_AXIS_TDATA};
        @(posedge clock);
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, CW'(exp_q.size()), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit early, s0_done, stalled, dropped;
        int n, stall, drop;

        resetn = 1'b0;
        clear_tracking();

        // ---- single S0 packet, 1..4, table driven (row 0 is the reset state) ----
        vecs[0] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b1};
        vecs[3] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 0, 1'b1};
        vecs[4] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 0, 1'b1};
        vecs[5] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 0, 1'b1};
        vecs[6] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4, 1'b1, 1'b0, 1, 1'b1};
        vecs[7] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1, 1'b1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            S0_AXIS_TVALID  = vecs[i].s0v;
            S0_AXIS_TDATA   = wide(vecs[i].s0d);
            S0_AXIS_TLAST   = vecs[i].s0l;
            S1_AXIS_TVALID  = 1'b0;
            OUT_AXIS_TREADY = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d.s0_ready", i), CW'(S0_AXIS_TREADY), CW'(vecs[i].e_s0r));
            chk($sformatf("vec%0d.s1_ready", i), CW'(S1_AXIS_TREADY), CW'(vecs[i].e_s1r));
            chk($sformatf("vec%0d.out_valid", i), CW'(OUT_AXIS_TVALID), CW'(vecs[i].e_ov));
            if (vecs[i].e_ov || i == 0) begin
                chk($sformatf("vec%0d.out_data", i), CW'(OUT_AXIS_TDATA), CW'(wide(vecs[i].e_od)));
                chk($sformatf("vec%0d.out_last", i), CW'(OUT_AXIS_TLAST), CW'(vecs[i].e_ol));
                chk($sformatf("vec%0d.out_user", i), CW'(OUT_AXIS_TUSER), CW'(vecs[i].e_ou));
            end
            chk($sformatf("vec%0d.pkt_count0", i), CW'(pkt_count0), CW'(vecs[i].e_c0));
            chk($sformatf("vec%0d.pkt_count1", i), CW'(pkt_count1), '0);
            chk($sformatf("vec%0d.busy", i), CW'(busy), CW'(vecs[i].e_busy));
        end

        // ---- both sources always valid, 3-beat packets, strict alternation ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_pkt(0, 16'h0100 + 16'(k * 16), 3);
            push_pkt(1, 16'h1100 + 16'(k * 16), 3);
        end
        en0 = 1; en1 = 1;
        drain("rr_drain", 80);
        chk("rr_beats", CW'(out_cnt), CW'(30));
        chk("rr_no_bubbles", CW'(last_out - first_out + 1), CW'(30));
        chk("rr_count0", CW'(pkt_count0), CW'(5));
        chk("rr_count1", CW'(pkt_count1), CW'(5));

        // ---- S1 arrives during beat 2 of an 8-beat S0 packet ----
        do_reset();
        push_pkt(0, 16'h2000, 8);
        push_pkt(1, 16'h2100, 3);
        en0 = 1;
        early = 0; s0_done = 0; n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (q0.size() <= 7) en1 = 1;
            step();
            if (!s0_done && st_s1r) early = 1;
            if (st_last0) s0_done = 1;
            n++;
        end
        chk("late_s1_drain", CW'(exp_q.size()), '0);
        chk("late_s1_held_off", CW'(early), '0);
        chk("late_s1_s0_done", CW'(s0_done), CW'(1));
        chk("late_s1_gap", CW'(s1_first_cyc - s0_last_cyc), CW'(1));

        // ---- downstream stall for 5 cycles mid-packet ----
        do_reset();
        push_pkt(0, 16'h3000, 6);
        en0 = 1;
        stall = 0; stalled = 0; n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (!stalled && out_cnt == 2) begin
                ordy = 0; stall = 5; stalled = 1;
            end
            step();
            if (stall > 0) begin
                stall--;
                if (stall == 0) ordy = 1;
            end
            n++;
        end
        chk("stall_drain", CW'(exp_q.size()), '0);
        chk("stall_beats", CW'(out_cnt), CW'(6));
        chk("stall_count0", CW'(pkt_count0), CW'(1));

        // ---- S0 drops TVALID for 3 cycles mid-packet while S1 waits ----
        do_reset();
        push_pkt(0, 16'h4000, 6);
        push_pkt(1, 16'h4100, 2);
        en0 = 1; en1 = 1;
        early = 0; s0_done = 0; drop = 0; dropped = 0; n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (!dropped && q0.size() == 4) begin
                en0 = 0; drop = 3; dropped = 1;
            end
            step();
            if (!s0_done && st_s1r) early = 1;
            if (st_last0) s0_done = 1;
            if (drop > 0) begin
                drop--;
                if (drop == 0) en0 = 1;
            end
            n++;
        end
        chk("gap_drain", CW'(exp_q.size()), '0);
        chk("gap_s1_held_off", CW'(early), '0);
        chk("gap_counts", CW'({pkt_count0, pkt_count1}), CW'({32'd1, 32'd1}));

        // ---- reset during beat 3 of a 6-beat packet ----
        do_reset();
        push_pkt(0, 16'h5000, 2);
        push_pkt(0, 16'h5100, 6);
        en0 = 1; n = 0;
        while (q0.size() > 4 && n < 40) begin
            step();
            n++;
        end
        chk("rst_reached_beat3", CW'(q0.size()), CW'(4));
        @(negedge clock);
        #1;
        chk("rst_pre_valid", CW'(OUT_AXIS_TVALID), CW'(1));
        chk("rst_pre_count0", CW'(pkt_count0), CW'(1));
        resetn = 1'b0;
        #1;
        chk("rst_out_valid", CW'(OUT_AXIS_TVALID), '0);
        chk("rst_out_data", CW'(OUT_AXIS_TDATA), '0);
        chk("rst_counts", CW'({pkt_count0, pkt_count1}), '0);
        chk("rst_readies", CW'({S0_AXIS_TREADY, S1_AXIS_TREADY}), '0);
        chk("rst_busy", CW'(busy), '0);
        @(negedge clock);
        @(negedge clock);
        clear_tracking();
        S0_AXIS_TVALID = 0;
        push_pkt(1, 16'h5200, 3);
        en1 = 1;
        resetn = 1'b1;
        drain("rst_after_drain", 20);
        chk("rst_after_beats", CW'(out_cnt), CW'(3));
        chk("rst_after_first_is_s1", CW'(s1_first_cyc), CW'(first_out));
        chk("rst_after_counts", CW'({pkt_count0, pkt_count1}), CW'({32'd0, 32'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsfp_tx_arbiter.md
# qsfp_tx_arbiter

Packet-atomic round-robin arbiter that shares the single 512-bit QSFP transmit stream between two AXI-Stream sources, e.g. the bandwidth-test generator and a second traffic source. A source holds the grant from its first beat until its TLAST beat is accepted. Then the grant rotates to the other source if it is waiting. Sits directly upstream of the QSFP TX interface. Output is registered, and the block keeps per-source packet counters for status readout.

## Interface
- DATA_W, 512: TDATA width of all streams.
- CNT_W, 32: width of the packet counters.
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- S0_AXIS_TDATA  in  DATA_W  source 0 data.
- S0_AXIS_TVALID  in  1  source 0 valid.
- S0_AXIS_TLAST  in  1  source 0 end of packet.
- S0_AXIS_TREADY  out  1  source 0 ready.
- S1_AXIS_TDATA / TVALID / TLAST / TREADY: same as S0, for source 1.
- OUT_AXIS_TDATA  out  DATA_W  arbitrated data.
- OUT_AXIS_TVALID  out  1  arbitrated valid.
- OUT_AXIS_TLAST  out  1  arbitrated end of packet.
- OUT_AXIS_TUSER  out  1  index of the source that produced the beat.
- OUT_AXIS_TREADY  in  1  downstream ready.
- pkt_count0, pkt_count1  out  CNT_W  packets forwarded per source (counted on TLAST accepted at the input).
- busy  out  1  high when state is not IDLE.

## Operation
- States:
  - IDLE: no source owns the output.
  - GRANT0: source 0 owns the output.
  - GRANT1: source 1 owns the output.
- last_grant register: index of the most recent grantee; reset value 1, so source 0 wins the first tie.
- IDLE:
  - Only one TVALID high: go to GRANT of that source.
  - Both high: go to GRANT of the source that is not last_grant.
  - Neither high: stay in IDLE.
  - last_grant is updated whenever a GRANT state is entered.
- GRANTn:
  - Sn_AXIS_TREADY = (!OUT_AXIS_TVALID || OUT_AXIS_TREADY). The other source's TREADY = 0.
  - An input beat is accepted when Sn TVALID && Sn TREADY.
  - An accepted beat loads the output register: TDATA, TLAST, TUSER = n, TVALID = 1.
  - Accepted beat with TLAST = 1:
    - pkt_countn increments; it wraps modulo 2^CNT_W with no saturation.
    - Re-arbitrate in the same cycle: if the other source's TVALID is high, go to GRANT(other); else if Sn TVALID is high, stay in GRANTn; else go to IDLE.
- Output register:
  - Cleared to TVALID = 0 when OUT_AXIS_TREADY is high and no new beat is accepted.
  - Holds its contents while OUT_AXIS_TVALID && !OUT_AXIS_TREADY (AXI-Stream stability rule).
- A source deasserting TVALID mid-packet keeps the grant; the arbiter waits indefinitely and has no timeout.
- S0_AXIS_TREADY and S1_AXIS_TREADY are never both high.

## Timing
- Reset values, all asserted asynchronously while resetn = 0:
  - state = IDLE, last_grant = 1.
  - OUT_AXIS_TVALID = 0, OUT_AXIS_TLAST = 0, OUT_AXIS_TUSER = 0, OUT_AXIS_TDATA = 0.
  - Both input TREADYs = 0, pkt_count0 = pkt_count1 = 0, busy = 0.
- Reset mid-packet: the partial packet is dropped at the output and the counters clear. After release, arbitration restarts from IDLE.
- Arbitration latency from IDLE: TVALID rises in cycle t; the GRANT state and TREADY are high in t+1; the first beat appears on OUT in t+2.
- Back-to-back packets with continuous OUT_AXIS_TREADY: zero bubbles within a packet and zero bubbles between packets of either source.
- Throughput: one beat per clock.
- Combinational paths:
  - OUT_AXIS_TREADY to Sn_AXIS_TREADY through one AND/OR level.
  - Input TVALIDs to the next-state logic only, never directly to TREADY.
- Counters update on the clock edge that accepts the TLAST beat.

## Structure
- Shared package holds:
  - the state encoding constants ARB_IDLE = 2'd0, ARB_GRANT0 = 2'd1, ARB_GRANT1 = 2'd2;
  - the source-index constants SRC_GEN = 0, SRC_AUX = 1, reused by the status register block.
- One natural sub-module: axis_out_reg, the one-deep registered output stage carrying TDATA, TLAST and TUSER, with a ready-through path. The arbiter FSM and counters stay in the top level.

## Test plan
- Only S0 valid; 4-beat packet with TDATA 1..4; OUT_AXIS_TREADY held high -> OUT shows 1..4 on consecutive cycles, TUSER = 0, TLAST on beat 4, pkt_count0 = 1, first OUT beat 2 cycles after S0 TVALID.
- Both sources continuously valid with 3-beat packets -> output order is S0, S1, S0, S1, no idle cycles between packets, and after 10 packets pkt_count0 = pkt_count1 = 5.
- S1 asserts TVALID during beat 2 of an 8-beat S0 packet -> S1_AXIS_TREADY stays 0 until S0's TLAST is accepted, and S1 data follows S0's TLAST on the next cycle.
- OUT_AXIS_TREADY held low for 5 cycles mid-packet -> OUT_AXIS_TDATA, TLAST and TUSER stay stable, S0 TREADY = 0, and no beat is lost or duplicated.
- S0 drops TVALID for 3 cycles mid-packet while S1 is valid -> the grant stays on S0 and S1 receives no TREADY until S0's TLAST.
- resetn pulsed low during beat 3 of a 6-beat packet -> OUT_AXIS_TVALID = 0 immediately and the counters read 0. After release with S1 valid, a fresh S1 packet is forwarded and is the first output.
